// File: rtl/dmem_access_sched.sv
// Two-port round-robin scheduler for one fixed-latency synchronous data memory.
// Define FIXED_PRIO_EN to give port 0 absolute priority under contention.
module dmem_access_sched #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rr_last_q, rr_last_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;
    unique case (state_q)
      IDLE: begin
`ifdef FIXED_PRIO_EN
        r0_gnt = r0_req;
        r1_gnt = r1_req && !r0_req;
`else
        // On a tie the port that did not win last time goes first.
        r0_gnt = r0_req && (!r1_req || rr_last_q);
        r1_gnt = r1_req && (!r0_req || !rr_last_q);
`endif
        if (r0_gnt) begin
          state_d   = ISSUE;
          owner_d   = 1'b0;
          rr_last_d = 1'b0;
          we_d      = r0_we;
          addr_d    = r0_addr;
          wdata_d   = r0_wdata;
        end else if (r1_gnt) begin
          state_d   = ISSUE;
          owner_d   = 1'b1;
          rr_last_d = 1'b1;
          we_d      = r1_we;
          addr_d    = r1_addr;
          wdata_d   = r1_wdata;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
          done0_d = !owner_q;
          done1_d = owner_q;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT4;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          done0_d = !owner_q;
          done1_d = owner_q;
          if (owner_q) rdata1_d = mem_rdata;
          else         rdata0_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rr_last_q <= 1'b1;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign r0_done   = done0_q;
  assign r1_done   = done1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_access_sched.sv
// Directed bench: one scheduler at latency 1, one at latency 3,
// each backed by a small behavioural memory.
module tb_dmem_access_sched;

  logic        clock;
  logic        resetn;

  logic        r0_req, r0_we, r0_gnt, r0_done;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_gnt, r1_done;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        s0_req, s0_we, s0_gnt, s0_done;
  logic [31:0] s0_addr, s0_wdata, s0_rdata;
  logic        s1_req, s1_we, s1_gnt, s1_done;
  logic [31:0] s1_addr, s1_wdata, s1_rdata;
  logic        smem_en, smem_we, s_busy;
  logic [31:0] smem_addr, smem_wdata, smem_rdata;

  logic [31:0] mem1 [256];
  logic [31:0] rp1;
  logic [31:0] mem3 [256];
  logic [31:0] sp0, sp1, sp2;
  int          en_cnt1 = 0;

  int vectors = 0;
  int errors  = 0;

  dmem_access_sched #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clock(clock), .resetn(resetn),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_done(r1_done),
    .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_access_sched #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u3 (
    .clock(clock), .resetn(resetn),
    .r0_req(s0_req), .r0_we(s0_we), .r0_addr(s0_addr),
    .r0_wdata(s0_wdata), .r0_gnt(s0_gnt), .r0_done(s0_done),
    .r0_rdata(s0_rdata),
    .r1_req(s1_req), .r1_we(s1_we), .r1_addr(s1_addr),
    .r1_wdata(s1_wdata), .r1_gnt(s1_gnt), .r1_done(s1_done),
    .r1_rdata(s1_rdata),
    .mem_en(smem_en), .mem_we(smem_we), .mem_addr(smem_addr),
    .mem_wdata(smem_wdata), .mem_rdata(smem_rdata), .busy(s_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Latency-1 memory: read data registered on the mem_en edge.
  always @(posedge clock) begin
    if (mem_en && mem_we) mem1[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) rp1 <= mem1[mem_addr[7:0]];
    if (mem_en) en_cnt1 <= en_cnt1 + 1;
  end
  assign mem_rdata = rp1;

  // Latency-3 memory: two extra pipeline stages.
  always @(posedge clock) begin
    if (smem_en && smem_we) mem3[smem_addr[7:0]] <= smem_wdata;
    if (smem_en && !smem_we) sp0 <= mem3[smem_addr[7:0]];
    sp1 <= sp0;
    sp2 <= sp1;
  end
  assign smem_rdata = sp2;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int g, c, rem0, rem1;
    logic want;
    resetn = 1'b0;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    s0_req = 0; s0_we = 0; s0_addr = 0; s0_wdata = 0;
    s1_req = 0; s1_we = 0; s1_addr = 0; s1_wdata = 0;

    // 1: reset state
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_gnt0", r0_gnt, 0);
    chk("rst_gnt1", r1_gnt, 0);
    chk("rst_done0", r0_done, 0);
    chk("rst_done1", r1_done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata0", r0_rdata, 0);
    chk("rst_rdata1", r1_rdata, 0);
    chk("rst_s_busy", s_busy, 0);
    chk("rst_s_mem_en", smem_en, 0);
    resetn = 1'b1;

    // 2: r0 write then read, latency 1
    r0_req = 1; r0_we = 1; r0_addr = 32'h10; r0_wdata = 32'hDEADBEEF;
    #1 chk("t2_wr_gnt", r0_gnt, 1);
    step();
    r0_req = 0;
    chk("t2_wr_busy", busy, 1);
    chk("t2_wr_en", mem_en, 1);
    chk("t2_wr_we", mem_we, 1);
    chk("t2_wr_addr", mem_addr, 32'h10);
    chk("t2_wr_data", mem_wdata, 32'hDEADBEEF);
    chk("t2_wr_gnt_busy", r0_gnt, 0);
    chk("t2_wr_nodone", r0_done, 0);
    step();
    chk("t2_wr_done", r0_done, 1);
    chk("t2_wr_en_off", mem_en, 0);
    step();
    chk("t2_wr_done_off", r0_done, 0);
    chk("t2_idle", busy, 0);
    r0_req = 1; r0_we = 0;
    #1 chk("t2_rd_gnt", r0_gnt, 1);
    step();
    r0_req = 0;
    chk("t2_rd_en", mem_en, 1);
    chk("t2_rd_we", mem_we, 0);
    step();
    chk("t2_rd_wait_busy", busy, 1);
    chk("t2_rd_wait_nodone", r0_done, 0);
    chk("t2_rd_wait_en", mem_en, 0);
    step();
    chk("t2_rd_done", r0_done, 1);
    chk("t2_rd_data", r0_rdata, 32'hDEADBEEF);
    chk("t2_en_count", en_cnt1, 2);
    step();
    chk("t2_rd_done_off", r0_done, 0);
    chk("t2_rd_hold", r0_rdata, 32'hDEADBEEF);

    // 3: contention, four reads per port
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    g = 0; c = 0; rem0 = 4; rem1 = 4;
    r0_we = 0; r1_we = 0; r0_addr = 32'h10; r1_addr = 32'h10;
    while (g < 8 && c < 100) begin
      r0_req = (rem0 > 0);
      r1_req = (rem1 > 0);
      #1;
      if (r0_gnt || r1_gnt) begin
`ifdef FIXED_PRIO_EN
        want = (g >= 4);
`else
        want = (g % 2 == 1);
`endif
        chk("t3_excl", r0_gnt & r1_gnt, 0);
        chk("t3_order", r1_gnt, want);
        if (r1_gnt) rem1--;
        else rem0--;
        g++;
      end
      step();
      c++;
    end
    chk("t3_count", g, 8);
    r0_req = 0; r1_req = 0;
    repeat (3) step();
    chk("t3_idle", busy, 0);

    // 6: r1 held off while r0 is in flight
    r0_req = 1; r0_we = 0; r0_addr = 32'h10;
    step();
    r0_req = 0;
    r1_req = 1; r1_we = 0; r1_addr = 32'h10;
    #1 chk("t6_gnt1_issue", r1_gnt, 0);
    step();
    chk("t6_gnt1_wait", r1_gnt, 0);
    step();
    chk("t6_r0_done", r0_done, 1);
    chk("t6_gnt1_done", r1_gnt, 0);
    step();
    chk("t6_gnt1_idle", r1_gnt, 1);
    step();
    r1_req = 0;
    chk("t6_r1_busy", busy, 1);
    step();
    step();
    chk("t6_r1_done", r1_done, 1);
    chk("t6_r1_data", r1_rdata, 32'hDEADBEEF);
    chk("t6_r0_quiet", r0_done, 0);
    step();

    // 5: reset during WAIT of an r0 read
    r0_req = 1; r0_we = 0; r0_addr = 32'h10;
    step();
    r0_req = 0;
    step();
    chk("t5_wait_busy", busy, 1);
    resetn = 1'b0;
    step();
    chk("t5_rst_idle", busy, 0);
    chk("t5_rst_nodone", r0_done, 0);
    chk("t5_rst_en", mem_en, 0);
    chk("t5_rst_rdata", r0_rdata, 0);
    resetn = 1'b1;
    step();
    chk("t5_post_nodone", r0_done, 0);
    chk("t5_post_en", mem_en, 0);
    r0_req = 1;
    #1 chk("t5_fresh_gnt", r0_gnt, 1);
    step();
    r0_req = 0;
    step();
    step();
    chk("t5_fresh_done", r0_done, 1);
    chk("t5_fresh_data", r0_rdata, 32'hDEADBEEF);
    step();

    // 4: latency 3 on the second instance, port 1
    s1_req = 1; s1_we = 1; s1_addr = 32'h20; s1_wdata = 32'hCAFEF00D;
    #1 chk("t4_wr_gnt", s1_gnt, 1);
    step();
    s1_req = 0;
    chk("t4_wr_en", smem_en, 1);
    chk("t4_wr_we", smem_we, 1);
    step();
    chk("t4_wr_done", s1_done, 1);
    step();
    s1_req = 1; s1_we = 0;
    step();
    s1_req = 0;
    chk("t4_rd_en", smem_en, 1);
    chk("t4_rd_we", smem_we, 0);
    step();
    chk("t4_wait1_busy", s_busy, 1);
    chk("t4_wait1_done", s1_done, 0);
    step();
    chk("t4_wait2_done", s1_done, 0);
    step();
    chk("t4_wait3_done", s1_done, 0);
    chk("t4_wait3_en", smem_en, 0);
    step();
    chk("t4_rd_done", s1_done, 1);
    chk("t4_rd_data", s1_rdata, 32'hCAFEF00D);
    chk("t4_r0_quiet", s0_done, 0);
    step();
    chk("t4_done_off", s1_done, 0);
    chk("t4_idle", s_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
